// File: rtl/dmem_responder.sv
// Word-addressed data memory with a req/gnt handshake, programmable wait states and a one-cycle rvalid response.
// Optional byte-lane store enables via `DMEM_RESP_BYTE_EN.
module dmem_responder #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DMEM_RESP_BYTE_EN
  input  logic [3:0]  be,
`endif
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
`ifdef DMEM_RESP_BYTE_EN
  logic [3:0]  lat_be;
`endif

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          fault;
  logic          do_write;
  logic [AW-1:0] widx;
  logic [31:0]   resp_rdata;

  // With WAIT=0 the access happens on the accept edge itself, so the live
  // request fields are used instead of the not-yet-latched copies.
  always_comb begin
    accept     = req && (state == IDLE);
    acc_we     = accept ? we    : lat_we;
    acc_addr   = accept ? addr  : lat_addr;
    acc_wdata  = accept ? wdata : lat_wdata;
`ifdef DMEM_RESP_BYTE_EN
    acc_be     = accept ? be    : lat_be;
`else
    acc_be     = '1;
`endif
    enter_resp = (accept && (WAIT_CNT == 4'd0)) ||
                 ((state == BUSY) && (cnt <= 4'd1));
    fault      = (acc_addr[1:0] != 2'b00) ||
                 ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    widx       = acc_addr[AW+1:2];
    do_write   = enter_resp && acc_we && !fault;
    resp_rdata = '0;
    if (enter_resp && !acc_we && !fault) begin
      resp_rdata = mem[widx];
    end
  end

  always_comb begin
    gnt = (state == IDLE) && reset;
  end

  // RAM contents survive reset; writes are gated so a reset edge never commits a store.
  always_ff @(posedge clk) begin
    if (reset && do_write) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[widx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef DMEM_RESP_BYTE_EN
      lat_be    <= '0;
`endif
      rvalid    <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
      if (enter_resp) begin
        rvalid <= 1'b1;
        err    <= fault;
        rdata  <= resp_rdata;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
`ifdef DMEM_RESP_BYTE_EN
            lat_be    <= be;
`endif
            if (WAIT_CNT == 4'd0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= WAIT_CNT;
            end
          end
        end
        BUSY: begin
          if (cnt <= 4'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
